kbd_cmd_seq: RTL

// - Host-side command sequencer for the PS/2 keyboard interface; sits between system logic, the PS/2 receiver and the host transmitter.
// - Accepts 1- or 2-byte keyboard commands (e.g. 0xED + LED mask) and sends each byte through the transmitter.
// - Owns host_oe: while it is high the receiver is held off the bus.
// - Waits for ACK 0xFA after each byte; retries on RESEND 0xFE; enforces a response timeout.
// - Forwards all non-response scan codes to the key path.

---
 rtl/kbd_pkg.sv | 31 +++
 rtl/kbd_tout_timer.sv | 26 ++
 rtl/kbd_cmd_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// Shared codes, FSM state and error encodings for the PS/2 host command sequencer.
// INIT/BATWAIT states exist only when KBD_CMD_SEQ_INIT_EN is defined.
package kbd_pkg;

    localparam logic [7:0] KBD_ACK        = 8'hFA;
    localparam logic [7:0] KBD_RESEND     = 8'hFE;
    localparam logic [7:0] KBD_BAT_OK     = 8'hAA;
    localparam logic [7:0] KBD_CMD_RESET  = 8'hFF;
    localparam logic [7:0] KBD_CMD_SETLED = 8'hED;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_TXWAIT,
        ST_ACKWAIT,
        ST_FIN
`ifdef KBD_CMD_SEQ_INIT_EN
        ,
        ST_INIT,
        ST_BATWAIT
`endif
    } seq_state_t;

    typedef enum logic [1:0] {
        ERR_OK    = 2'b00,
        ERR_TOUT  = 2'b01,
        ERR_RETRY = 2'b10,
        ERR_TX    = 2'b11
    } cmd_err_t;

endpackage

// File: rtl/kbd_tout_timer.sv
// Saturating 32-bit response timer; expired once the count reaches limit_i-1.
module kbd_tout_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [31:0] limit_i,
    output logic        expired_o
);

    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    // Widened so a limit of 0 expires at once instead of wrapping.
    assign expired_o = ({1'b0, cnt_q} + 33'd1) >= {1'b0, limit_i};

endmodule

// File: rtl/kbd_cmd_seq.sv
// PS/2 host command sequencer: sends 1-2 byte commands, handles ACK/RESEND/timeout, forwards scan codes.
// Define KBD_CMD_SEQ_INIT_EN to send a keyboard reset and wait for BAT after reset.
module kbd_cmd_seq
    import kbd_pkg::*;
#(
    parameter logic [31:0] ACK_TOUT  = 32'd2_000_000,
    parameter int unsigned MAX_RETRY = 3,
    parameter logic [31:0] BAT_TOUT  = 32'd100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_req,
    input  logic [7:0] cmd_byte,
    input  logic       cmd_has_arg,
    input  logic [7:0] cmd_arg,
    output logic       cmd_busy,
    output logic       cmd_done,
    output logic [1:0] cmd_err,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    input  logic       tx_fail,
    output logic       host_oe,
    input  logic [7:0] scode,
    input  logic       scode_en,
    output logic [7:0] key_code,
    output logic       key_en
);

    seq_state_t  state_q, state_d;
    logic [7:0]  cmd_q, cmd_d, arg_q, arg_d;
    logic        has_arg_q, has_arg_d, byte_sel_q, byte_sel_d;
    logic [31:0] retry_q, retry_d;
    cmd_err_t    err_d;
    logic        tmr_clr, tmr_en, tmr_expired, consume, bat_phase;
    logic [31:0] tout_limit;

    logic        tx_start_q, host_oe_q, cmd_done_q, key_en_q;
    logic [7:0]  tx_data_q, key_code_q;
    logic [1:0]  cmd_err_q;

`ifdef KBD_CMD_SEQ_INIT_EN
    logic        init_q, init_d;
    assign bat_phase = (state_q == ST_BATWAIT);
`else
    assign bat_phase = 1'b0;
`endif

    assign tout_limit = bat_phase ? BAT_TOUT : ACK_TOUT;

    kbd_tout_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .limit_i   (tout_limit),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        arg_d      = arg_q;
        has_arg_d  = has_arg_q;
        byte_sel_d = byte_sel_q;
        retry_d    = retry_q;
        err_d      = ERR_OK;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        consume    = 1'b0;
`ifdef KBD_CMD_SEQ_INIT_EN
        init_d     = init_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_req) begin
                    cmd_d      = cmd_byte;
                    arg_d      = cmd_arg;
                    has_arg_d  = cmd_has_arg;
                    byte_sel_d = 1'b0;
                    retry_d    = '0;
                    state_d    = ST_SEND;
                end
            end
            ST_SEND: state_d = ST_TXWAIT;
            ST_TXWAIT: begin
                if (tx_done) begin
                    if (tx_fail) begin
                        err_d   = ERR_TX;
                        state_d = ST_FIN;
                    end else begin
                        tmr_clr = 1'b1;
                        state_d = ST_ACKWAIT;
                    end
                end
            end
            ST_ACKWAIT: begin
                tmr_en = 1'b1;
                if (scode_en && (scode == KBD_ACK)) begin
                    consume = 1'b1;
                    if (!byte_sel_q && has_arg_q) begin
                        byte_sel_d = 1'b1;
                        retry_d    = '0;
                        state_d    = ST_SEND;
`ifdef KBD_CMD_SEQ_INIT_EN
                    end else if (init_q) begin
                        tmr_clr = 1'b1;
                        state_d = ST_BATWAIT;
`endif
                    end else begin
                        state_d = ST_FIN;
                    end
                end else if (scode_en && (scode == KBD_RESEND)) begin
                    consume = 1'b1;
                    if (retry_q < MAX_RETRY) begin
                        retry_d = retry_q + 32'd1;
                        state_d = ST_SEND;
                    end else begin
                        err_d   = ERR_RETRY;
                        state_d = ST_FIN;
                    end
                end else if (tmr_expired && !scode_en) begin
                    // Any strobe holds off the timeout for a cycle; the saturated count catches it next cycle.
                    err_d   = ERR_TOUT;
                    state_d = ST_FIN;
                end
            end
            ST_FIN: state_d = ST_IDLE;
`ifdef KBD_CMD_SEQ_INIT_EN
            ST_INIT: begin
                init_d     = 1'b1;
                cmd_d      = KBD_CMD_RESET;
                has_arg_d  = 1'b0;
                byte_sel_d = 1'b0;
                retry_d    = '0;
                state_d    = ST_SEND;
            end
            ST_BATWAIT: begin
                tmr_en = 1'b1;
                if (scode_en && (scode == KBD_BAT_OK)) begin
                    consume = 1'b1;
                    state_d = ST_FIN;
                end else if (tmr_expired && !scode_en) begin
                    err_d   = ERR_TOUT;
                    state_d = ST_FIN;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
`ifdef KBD_CMD_SEQ_INIT_EN
        // Power-up sequence reports every failure as a timeout.
        if (init_q && (state_d == ST_FIN)) begin
            err_d  = (err_d == ERR_OK) ? ERR_OK : ERR_TOUT;
            init_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef KBD_CMD_SEQ_INIT_EN
            state_q <= ST_INIT;
            init_q  <= 1'b1;
`else
            state_q <= ST_IDLE;
`endif
            byte_sel_q <= 1'b0;
            retry_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            host_oe_q  <= 1'b0;
            cmd_done_q <= 1'b0;
            cmd_err_q  <= 2'b00;
            key_en_q   <= 1'b0;
            key_code_q <= 8'h00;
        end else begin
            state_q    <= state_d;
`ifdef KBD_CMD_SEQ_INIT_EN
            init_q     <= init_d;
`endif
            byte_sel_q <= byte_sel_d;
            retry_q    <= retry_d;
            tx_start_q <= (state_q == ST_SEND);
            if (state_q == ST_SEND) begin
                tx_data_q <= byte_sel_q ? arg_q : cmd_q;
                host_oe_q <= 1'b1;
            end else if ((state_q == ST_TXWAIT) && tx_done) begin
                host_oe_q <= 1'b0;
            end
            cmd_done_q <= (state_d == ST_FIN);
            cmd_err_q  <= (state_d == ST_FIN) ? err_d : ERR_OK;
            key_en_q   <= scode_en && !host_oe_q && !consume;
            if (scode_en && !host_oe_q && !consume) begin
                key_code_q <= scode;
            end
        end
    end

    // Command payload is only meaningful once latched, so it carries no reset.
    always_ff @(posedge clk) begin
        cmd_q     <= cmd_d;
        arg_q     <= arg_d;
        has_arg_q <= has_arg_d;
    end

    assign cmd_busy = (state_q != ST_IDLE);
    assign cmd_done = cmd_done_q;
    assign cmd_err  = cmd_err_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign host_oe  = host_oe_q;
    assign key_en   = key_en_q;
    assign key_code = key_code_q;

endmodule
